uart_bcd_receiver: RTL and testbench
====================================

Name: uart_bcd_receiver

Overview:
- Serial receive front end for the calculator's display path.
- Deserialises 8N1 UART bytes from the host on rxd and converts each byte to unsigned decimal digits.
- Drives the digit bus (n, num1..num4) that feeds the seven-segment display driver.
- Replaces ad-hoc divide/modulo conversion with a sequential shift-add-3 converter; no dividers are used.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit. Tick divisor = CLK_FREQ/(BAUD*OVERSAMPLE), truncated; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rxd  in  1  UART line; idles high; asynchronous to clk.
- clear  in  1  synchronous request to blank the digit outputs.
- n  out  4  number of significant digits, 0..3.
- num1  out  4  thousands digit; always 0 for 8-bit data.
- num2  out  4  hundreds digit.
- num3  out  4  tens digit.
- num4  out  4  ones digit.
- data_ready  out  1  one-cycle pulse when the digit outputs update.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: n=0, num1..num4=0, data_ready=0, frame_err=0, busy=0, FSM=IDLE, synchroniser flops=1.
- Input sync: rxd passes through a 2-flop synchroniser; all rxd references below mean the synchronised value.
- Tick generator: free-running counter wraps at divisor-1 and emits a 1-cycle tick. It restarts to 0 on entering START, so sampling is phase-aligned to the start edge.
- FSM states: IDLE, START, DATA, STOP, CONV, DONE.
  - IDLE: rxd=0 -> START.
  - START: after OVERSAMPLE/2 ticks, sample rxd. 0 -> DATA with bit index 0. 1 -> IDLE (glitch rejected, no error).
  - DATA: every OVERSAMPLE ticks, sample one bit into a shift register, LSB first. After bit 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample rxd. 1 -> CONV. 0 -> frame_err pulse, byte discarded, outputs unchanged. On error, wait in STOP until rxd=1, then go to IDLE; this prevents a break condition from retriggering.
  - CONV: double-dabble over the 8-bit byte into a 12-bit BCD register. One shift per clock (not per tick), 8 cycles exactly. Before each shift, add 3 to any BCD nibble >= 5.
  - DONE: on the clock edge leaving DONE, load num2/num3/num4 from the BCD nibbles and set num1=0. data_ready is high for that one cycle. Next state is IDLE.
- Latency: stop-bit sample at cycle S; conversion occupies S+1..S+8; data_ready and the new digits appear at cycle S+9.
- Significant-digit count: n = 3 if value >= 100; 2 if value >= 10; 1 otherwise. Value 0 gives n=1, num4=0.
- clear:
  - Sets n=0 and num1..num4=0 on the next edge.
  - Does not abort a frame in progress; a later DONE overwrites the cleared outputs.
  - If clear and a DONE update fall in the same cycle, clear wins: outputs are zeroed and data_ready is suppressed.
- Back-to-back frames: a start bit arriving during CONV/DONE is seen on return to IDLE. CONV+DONE take 9 clocks, which is less than half a bit time, so the start bit is never missed.
- Reset mid-frame: everything returns to reset values immediately; the partial byte is lost.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state sits between DATA and STOP and samples the parity bit.
  - Adds output parity_err (1 bit, reset 0): one-cycle pulse when XOR of the data bits and the parity bit is 1.
  - On a parity error the byte is discarded, and the STOP state is still traversed before returning to IDLE.
- Undefined: 8N1 framing; no PARITY state and no parity_err port.

Decomposition:
- Package uart_bcd_pkg holds:
  - FSM state enum (uart_rx_state_t).
  - Tick divisor function of CLK_FREQ/BAUD/OVERSAMPLE.
  - DATA_BITS=8 and BCD_DIGITS=3 constants.
  - Digit-count function (value -> n).
- One sub-module, bin2bcd_seq:
  - Sequential double-dabble with start/done handshake: start pulse, done pulse 8 cycles later, 8-bit in, 12-bit out.
  - Bit receiver and FSM remain in the top module.

Test Plan:
- All scenarios use CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, giving divisor 10 and 160 clocks per bit.
- Send 0xFF (8N1) -> data_ready one cycle at S+9; num1..num4=0,2,5,5; n=3; frame_err=0.
- Send 0x07 then 0x0A back-to-back, no idle gap -> two data_ready pulses; first digits 0,0,0,7 with n=1; second 0,0,1,0 with n=2.
- Send 0x00 -> digits 0,0,0,0 with n=1. Then assert clear one cycle -> n=0, all digits 0; no data_ready.
- rxd low for 60 clocks, then high -> glitch rejected; busy returns low; no data_ready, no frame_err.
- Send 0x55 with stop bit forced 0 for 2 bit times -> frame_err one pulse; outputs keep previous values; next valid 0x64 gives digits 0,1,0,0 with n=3.
- Pull reset low during DATA of 0x80, release, then send 0x2A -> outputs 0 during reset; afterwards digits 0,0,4,2 with n=2. With UART_PARITY_EN, also send 0x2A with odd parity -> parity_err pulse, outputs unchanged.

Source files
------------

// File: rtl/uart_bcd_pkg.sv
// rtl/uart_bcd_pkg.sv - shared types, constants and helpers for the UART BCD receiver
//
// Contents:
//   DATA_BITS, BCD_DIGITS : frame payload width and number of BCD nibbles produced
//   uart_rx_state_t       : receiver FSM states (ST_PARITY only when UART_PARITY_EN is defined)
//   tick_divisor()        : clocks per oversample tick, truncated
//   digit_count()         : number of significant decimal digits of a byte
package uart_bcd_pkg;

    localparam int DATA_BITS  = 8;
    localparam int BCD_DIGITS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_CONV,
        ST_DONE
    } uart_rx_state_t;

    // Result must be >= 2 for the tick generator to produce isolated pulses.
    function automatic int tick_divisor(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // Zero still shows one digit; the display blanks only on n == 0.
    function automatic logic [3:0] digit_count(input logic [DATA_BITS-1:0] value);
        if (value >= 8'd100) begin
            return 4'd3;
        end else if (value >= 8'd10) begin
            return 4'd2;
        end else begin
            return 4'd1;
        end
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   start  : one-cycle pulse; captures bin and clears the BCD accumulator
//   bin    : DATA_BITS-wide binary input, sampled on start
//   bcd    : 4*BCD_DIGITS-wide result, valid while done is high and until the next start
//   done   : one-cycle pulse after the last of DATA_BITS shifts (DATA_BITS cycles after start)
module bin2bcd_seq
    import uart_bcd_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_BITS-1:0]      bin,
    output logic [4*BCD_DIGITS-1:0]   bcd,
    output logic                      done
);

    localparam int CW = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0]    sr;
    logic [CW-1:0]           cnt;
    logic                    running;
    logic [4*BCD_DIGITS-1:0] adj;

    // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next decade.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr      <= bin;
                bcd     <= '0;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                bcd <= {adj[4*BCD_DIGITS-2:0], sr[DATA_BITS-1]};
                sr  <= {sr[DATA_BITS-2:0], 1'b0};
                cnt <= cnt + CW'(1);
                if (cnt == CW'(DATA_BITS - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_bcd_receiver.sv
// rtl/uart_bcd_receiver.sv - UART byte receiver driving a decimal digit bus
//
// Optional build macro: UART_PARITY_EN (8E1 framing, adds parity_err output).
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   rxd        : UART line, idles high, asynchronous to clk
//   clear      : synchronous request to blank the digit outputs
//   n          : number of significant digits (0 = blank, 1..3)
//   num1..num4 : thousands, hundreds, tens, ones digits (num1 always 0)
//   data_ready : one-cycle pulse when the digits update
//   busy       : high whenever the receiver is not idle
//   frame_err  : one-cycle pulse on a low stop bit
//   parity_err : one-cycle pulse on even-parity failure (UART_PARITY_EN only)
module uart_bcd_receiver
    import uart_bcd_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       clear,
    output logic [3:0] n,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic       data_ready,
    output logic       busy,
    output logic       frame_err
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV = tick_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    uart_rx_state_t          state;
    logic                    rxd_m;
    logic                    rxd_s;
    logic [TW-1:0]           tick_cnt;
    logic                    tick;
    logic [SW-1:0]           s_cnt;
    logic [BW-1:0]           bit_idx;
    logic [DATA_BITS-1:0]    shreg;
    logic                    err_wait;
    logic                    conv_start;
    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic                    conv_done;
    logic                    mid_bit;
    logic                    byte_ok;
`ifdef UART_PARITY_EN
    logic                    par_bad;
`endif

    // Two-flop synchroniser; idles at 1 so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Free-running tick, re-phased on the falling start edge so samples land mid-bit.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if ((state == ST_IDLE) && !rxd_s) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign busy    = (state != ST_IDLE);
    assign mid_bit = tick && (s_cnt == FULL_LAST);

`ifdef UART_PARITY_EN
    assign byte_ok = !par_bad;
`else
    assign byte_ok = 1'b1;
`endif

    // Converter is loaded on the very edge that samples a good stop bit, so the
    // eight shifts line up exactly with the eight CONV cycles.
    assign conv_start = (state == ST_STOP) && !err_wait && mid_bit && rxd_s && byte_ok;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (shreg),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            s_cnt      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            err_wait   <= 1'b0;
            n          <= 4'd0;
            num1       <= 4'd0;
            num2       <= 4'd0;
            num3       <= 4'd0;
            num4       <= 4'd0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (clear) begin
                n    <= 4'd0;
                num1 <= 4'd0;
                num2 <= 4'd0;
                num3 <= 4'd0;
                num4 <= 4'd0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state <= ST_START;
                        s_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (s_cnt == HALF_LAST) begin
                            s_cnt   <= '0;
                            bit_idx <= '0;
                            // A line already back high at mid start bit is a glitch, not a frame.
                            state   <= rxd_s ? ST_IDLE : ST_DATA;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (s_cnt == FULL_LAST) begin
                            s_cnt   <= '0;
                            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + BW'(1);
                            if (bit_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end

`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        if (s_cnt == FULL_LAST) begin
                            s_cnt      <= '0;
                            par_bad    <= ^{shreg, rxd_s};
                            parity_err <= ^{shreg, rxd_s};
                            state      <= ST_STOP;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
`endif

                ST_STOP: begin
                    if (err_wait) begin
                        // Hold off until the line idles so a break cannot look like a new start bit.
                        if (rxd_s) begin
                            err_wait <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end else if (tick) begin
                        if (s_cnt == FULL_LAST) begin
                            s_cnt <= '0;
                            if (!rxd_s) begin
                                frame_err <= 1'b1;
                                err_wait  <= 1'b1;
                            end else if (conv_start) begin
                                bit_idx <= '0;
                                state   <= ST_CONV;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end

                ST_CONV: begin
                    bit_idx <= bit_idx + BW'(1);
                    if (bit_idx == IDX_LAST) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    // A simultaneous clear wins: outputs stay blank and no update is announced.
                    if (!clear && conv_done) begin
                        n          <= digit_count(shreg);
                        num1       <= 4'd0;
                        num2       <= conv_bcd[11:8];
                        num3       <= conv_bcd[7:4];
                        num4       <= conv_bcd[3:0];
                        data_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bcd_receiver.sv
// tb/tb_uart_bcd_receiver.sv - self-checking bench for uart_bcd_receiver
module tb_uart_bcd_receiver;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BITC       = 160;

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int STOP_START = (FRAME_BITS - 1) * BITC;
    localparam int FRAME_CLKS = FRAME_BITS * BITC;
    // Start edge reaches the FSM 3 edges after the line falls (2 sync flops + IDLE),
    // then half a bit to mid start bit, then whole bits to mid stop bit.
    localparam int S_CYC      = 3 + BITC / 2 + (FRAME_BITS - 1) * BITC;
    localparam int DR_CYC     = S_CYC + 9;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       clear;
    logic [3:0] n;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic       data_ready;
    logic       busy;
    logic       frame_err;
`ifdef UART_PARITY_EN
    logic       parity_err;
    logic       force_bad_par;
    int         pe_cnt;
`endif

    int pass_cnt;
    int total_cnt;
    int dr_cnt;
    int dr_cyc;
    int fe_cnt;
    int fe_cyc;
    int busy_seen;
    logic [7:0] last_val;
    logic [7:0] stim [8];

    uart_bcd_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .clear      (clear),
        .n          (n),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err)
`ifdef UART_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: decimal digits by plain division, digit count by magnitude.
    function automatic int ref_n(input int v);
        return (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
    endfunction

    task automatic chk_digits(input string tag, input int v);
        chk({tag, ".n"},    n,    ref_n(v));
        chk({tag, ".num1"}, num1, v / 1000);
        chk({tag, ".num2"}, num2, (v / 100) % 10);
        chk({tag, ".num3"}, num3, (v / 10) % 10);
        chk({tag, ".num4"}, num4, v % 10);
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, ".n"},    n,    0);
        chk({tag, ".num1"}, num1, 0);
        chk({tag, ".num2"}, num2, 0);
        chk({tag, ".num3"}, num3, 0);
        chk({tag, ".num4"}, num4, 0);
    endtask

    function automatic logic line_bit(input int c, input logic [7:0] d, input int stop_low);
        if (c < BITC) return 1'b0;
        if (c < 9 * BITC) return d[3'((c - BITC) / BITC)];
`ifdef UART_PARITY_EN
        if (c < 10 * BITC) return (^d) ^ force_bad_par;
`endif
        if (c < STOP_START + stop_low) return 1'b0;
        return 1'b1;
    endfunction

    // Drives one frame, one clock per iteration, starting and ending at a negedge.
    // clear_at names the clock edge (1-based) at which clear is sampled high; 0 = never.
    task automatic send_frame(input logic [7:0] d, input int stop_low, input int clear_at);
        int len;
        len = FRAME_CLKS + stop_low;
        dr_cnt = 0; dr_cyc = 0; fe_cnt = 0; fe_cyc = 0; busy_seen = 0;
`ifdef UART_PARITY_EN
        pe_cnt = 0;
`endif
        for (int c = 0; c < len; c++) begin
            rxd   = line_bit(c, d, stop_low);
            clear = (c + 1 == clear_at);
            @(posedge clk);
            @(negedge clk);
            if (data_ready === 1'b1) begin dr_cnt++; dr_cyc = c + 1; end
            if (frame_err === 1'b1) begin fe_cnt++; fe_cyc = c + 1; end
            if (busy === 1'b1) busy_seen++;
`ifdef UART_PARITY_EN
            if (parity_err === 1'b1) pe_cnt++;
`endif
        end
        clear = 1'b0;
    endtask

    task automatic good_frame(input string tag, input logic [7:0] d);
        send_frame(d, 0, 0);
        chk({tag, ".dr_cnt"}, dr_cnt, 1);
        chk({tag, ".dr_cyc"}, dr_cyc, DR_CYC);
        chk({tag, ".fe_cnt"}, fe_cnt, 0);
        chk_digits(tag, int'(d));
        last_val = d;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b0; rxd = 1'b1; clear = 1'b0;
`ifdef UART_PARITY_EN
        force_bad_par = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_blank("reset");
        chk("reset.data_ready", data_ready, 0);
        chk("reset.busy", busy, 0);
        chk("reset.frame_err", frame_err, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        good_frame("ff", 8'hFF);

        good_frame("b2b_07", 8'h07);
        good_frame("b2b_0a", 8'h0A);

        good_frame("zero", 8'h00);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear.data_ready", data_ready, 0);
        chk_blank("clear");
        repeat (5) @(negedge clk);

        good_frame("c8", 8'hC8);
        send_frame(8'h99, 0, DR_CYC);
        chk("clr_done.dr_cnt", dr_cnt, 0);
        chk_blank("clr_done");

        good_frame("pre", 8'h31);

        dr_cnt = 0; fe_cnt = 0; busy_seen = 0;
        for (int c = 0; c < 260; c++) begin
            rxd = (c < 60) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (data_ready === 1'b1) dr_cnt++;
            if (frame_err === 1'b1) fe_cnt++;
            if (busy === 1'b1) busy_seen++;
        end
        chk("glitch.busy_seen", busy_seen > 0, 1);
        chk("glitch.busy_end", busy, 0);
        chk("glitch.dr_cnt", dr_cnt, 0);
        chk("glitch.fe_cnt", fe_cnt, 0);
        chk_digits("glitch", int'(last_val));

        send_frame(8'h55, 2 * BITC, 0);
        chk("ferr.fe_cnt", fe_cnt, 1);
        chk("ferr.fe_cyc", fe_cyc, S_CYC);
        chk("ferr.dr_cnt", dr_cnt, 0);
        chk("ferr.busy_end", busy, 0);
        chk_digits("ferr", int'(last_val));
        good_frame("after_ferr", 8'h64);

        rxd = 1'b0;
        repeat (400) @(negedge clk);
        chk("midreset.busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk_blank("midreset");
        chk("midreset.busy", busy, 0);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        good_frame("after_reset", 8'h2A);

`ifdef UART_PARITY_EN
        force_bad_par = 1'b1;
        send_frame(8'h2A, 0, 0);
        force_bad_par = 1'b0;
        chk("parity.pe_cnt", pe_cnt, 1);
        chk("parity.dr_cnt", dr_cnt, 0);
        chk("parity.fe_cnt", fe_cnt, 0);
        chk_digits("parity", int'(last_val));
`endif

        stim[0] = 8'd9;
        stim[1] = 8'd99;
        for (int i = 2; i < 8; i++) stim[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            good_frame($sformatf("rand%0d_%0d", i, stim[i]), stim[i]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
